// File: rtl/fifo_uart_tx_if.sv
// Bus between the FIFO read port and the UART drain stage, plus the serial pin and status.
// fifo_rd_en is a one-cycle pop strobe, issued only while fifo_empty is low; fifo_data is taken the cycle after.
interface fifo_uart_tx_if;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       byte_done;

    modport master (
        input  enable,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output tx,
        output busy,
        output byte_done
    );

    modport slave (
        output enable,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  byte_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time and serialises it as an 8N1 UART frame.
// All outputs are registered; the FSM state is exported on state_o.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fifo_uart_tx_if.master       bus_io,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             rd_en_q;
    logic             busy_q;
    logic             done_q;

    logic             cnt_wrap;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       shift_d;

    assign cnt_wrap = (cnt_q == CNT_LAST);
    assign cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    assign shift_d  = {1'b0, shift_q[7:1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    if (bus_io.enable && !bus_io.fifo_empty) begin
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_LOAD;
                end
                // Popped byte is on the FIFO output now; this is the only place it is sampled.
                S_LOAD: begin
                    shift_q <= bus_io.fifo_data;
                    tx_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_START;
                end
                S_START: begin
                    cnt_q <= cnt_d;
                    if (cnt_wrap) begin
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    cnt_q <= cnt_d;
                    if (cnt_wrap) begin
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            shift_q   <= shift_d;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    cnt_q <= cnt_d;
                    if (cnt_wrap) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_io.fifo_rd_en = rd_en_q;
    assign bus_io.tx         = tx_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.byte_done  = done_q;
    assign state_o           = state_q;

endmodule
